// File: rtl/reg_rr_write_arbiter_pkg.sv
// rtl/reg_rr_write_arbiter_pkg.sv - shared types and helpers for the shared-register write arbiter
// Purpose: lock FSM state type, counter-width helper and modular index helper.
// Ports: none (package).
package reg_rr_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Bits needed to count from 0 up to max_cnt inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return (max_cnt < 2) ? 1 : $clog2(max_cnt + 1);
  endfunction

  // (base + step) mod n, used to walk the requesters in rotating order.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned step,
                                           input int unsigned n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/reg_rr_write_arbiter_if.sv
// rtl/reg_rr_write_arbiter_if.sv - write-request bus between requesters and the shared register
// Purpose: bundles the priority port, requester requests/data and arbiter status.
// Ports (signals):
//   PRI_EN, PRI_D      priority write enable / data
//   REQ, LOCK, D_IN    per-requester request, lock request, packed data
//   GNT                one-hot combinational grant
//   Q_OUT              register contents
//   WR_VALID/IDX/PRI   registered write status of the previous edge
// Modports: master drives requests, slave is the arbiter.
interface reg_rr_write_arbiter_if #(
  parameter int nreq  = 4,
  parameter int idxw  = 2,
  parameter int width = 8
);

  logic                    PRI_EN;
  logic [width-1:0]        PRI_D;
  logic [nreq-1:0]         REQ;
  logic [nreq-1:0]         LOCK;
  logic [nreq*width-1:0]   D_IN;
  logic [nreq-1:0]         GNT;
  logic [width-1:0]        Q_OUT;
  logic                    WR_VALID;
  logic [idxw-1:0]         WR_IDX;
  logic                    WR_PRI;

  modport master (
    output PRI_EN, PRI_D, REQ, LOCK, D_IN,
    input  GNT, Q_OUT, WR_VALID, WR_IDX, WR_PRI
  );

  modport slave (
    input  PRI_EN, PRI_D, REQ, LOCK, D_IN,
    output GNT, Q_OUT, WR_VALID, WR_IDX, WR_PRI
  );

endinterface

// File: rtl/reg_rr_write_arbiter_rr_pick.sv
// rtl/reg_rr_write_arbiter_rr_pick.sv - combinational rotating priority encoder
// Purpose: picks the first set request after i_ptr, wrapping modulo nreq.
// Ports:
//   i_req  request vector
//   i_ptr  index of the last winner; search starts at i_ptr+1
//   o_gnt  one-hot winner (zero if no request)
//   o_idx  winner index
//   o_any  at least one request present
module reg_rr_write_arbiter_rr_pick
  import reg_rr_write_arbiter_pkg::*;
#(
  parameter int nreq = 4,
  parameter int idxw = 2
) (
  input  logic [nreq-1:0] i_req,
  input  logic [idxw-1:0] i_ptr,
  output logic [nreq-1:0] o_gnt,
  output logic [idxw-1:0] o_idx,
  output logic            o_any
);

  logic [idxw-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= nreq; k++) begin
      w_cand = idxw'(wrap_idx(32'(i_ptr), k, nreq));
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/reg_rr_write_arbiter.sv
// rtl/reg_rr_write_arbiter.sv - round-robin arbitrated writes into one shared register
// Purpose: nreq requesters and one absolute-priority port share a width-bit register.
//   At most one requester is granted per cycle in round-robin order; PRI_EN beats all.
//   Optional feature macro REG_ARB_LOCK_EN: a granted requester holding LOCK keeps
//   exclusive ownership for up to max_lock consecutive grants.
// Ports:
//   CLK    clock, posedge
//   RST_N  synchronous reset, active-low
//   bus    reg_rr_write_arbiter_if.slave (requests, grant, register, write status)
module reg_rr_write_arbiter
  import reg_rr_write_arbiter_pkg::*;
#(
  parameter int               nreq     = 4,
  parameter int               idxw     = 2,
  parameter int               width    = 8,
  parameter logic [width-1:0] init     = '0,
  parameter int               max_lock = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  reg_rr_write_arbiter_if.slave bus
);

  logic [width-1:0] r_q;
  logic             r_wr_valid;
  logic [idxw-1:0]  r_wr_idx;
  logic             r_wr_pri;
  logic [idxw-1:0]  r_rr_ptr;

  logic [nreq-1:0]  w_req_eff;
  logic [nreq-1:0]  w_pick_gnt;
  logic [idxw-1:0]  w_pick_idx;
  logic             w_pick_any;
  logic             w_accept;
  logic [width-1:0] w_sel_d;

`ifdef REG_ARB_LOCK_EN
  localparam int cntw = cnt_width(max_lock);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [idxw-1:0]  r_owner;
  logic [idxw-1:0]  w_owner_nxt;
  logic [cntw-1:0]  r_lock_cnt;
  logic [cntw-1:0]  w_lock_cnt_nxt;
  logic             w_hold;

  // The lock only restricts arbitration while the owner still asserts LOCK; once it
  // lets go, this cycle is arbitrated as if unlocked so nobody loses a cycle.
  assign w_hold = (r_state == ST_LOCKED) && bus.LOCK[r_owner];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_hold) begin
      if (bus.PRI_EN) begin
        // Preempted: ownership and count are frozen for this cycle.
        w_state_nxt = ST_LOCKED;
      end else if (!bus.REQ[r_owner]) begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = '0;
      end else if (int'(r_lock_cnt) + 1 >= max_lock) begin
        // This grant is the last one allowed; it completes, then the lock is released.
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = '0;
      end else begin
        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
      end
    end else begin
      w_state_nxt    = ST_IDLE;
      w_lock_cnt_nxt = '0;
      if (w_accept && bus.LOCK[w_pick_idx] && (max_lock > 1)) begin
        w_state_nxt    = ST_LOCKED;
        w_owner_nxt    = w_pick_idx;
        w_lock_cnt_nxt = cntw'(1);
      end
    end
  end

  always_comb begin
    w_req_eff = bus.REQ;
    if (w_hold) begin
      w_req_eff = bus.REQ & (nreq'(1) << r_owner);
    end
  end
`else
  logic w_lock_unused;
  assign w_lock_unused = ^bus.LOCK;
  assign w_req_eff     = bus.REQ;
`endif

  reg_rr_write_arbiter_rr_pick #(
    .nreq (nreq),
    .idxw (idxw)
  ) u_pick (
    .i_req (w_req_eff),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_accept = RST_N && !bus.PRI_EN && w_pick_any;
  assign bus.GNT  = w_accept ? w_pick_gnt : '0;
  assign w_sel_d  = bus.D_IN[w_pick_idx*width +: width];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_q        <= init;
      r_wr_valid <= 1'b0;
      r_wr_idx   <= '0;
      r_wr_pri   <= 1'b0;
      // Pointer at the last requester so requester 0 is searched first.
      r_rr_ptr   <= idxw'(nreq - 1);
    end else if (bus.PRI_EN) begin
      r_q        <= bus.PRI_D;
      r_wr_valid <= 1'b1;
      r_wr_pri   <= 1'b1;
    end else if (w_accept) begin
      r_q        <= w_sel_d;
      r_wr_valid <= 1'b1;
      r_wr_pri   <= 1'b0;
      r_wr_idx   <= w_pick_idx;
      r_rr_ptr   <= w_pick_idx;
    end else begin
      r_wr_valid <= 1'b0;
    end
  end

  assign bus.Q_OUT    = r_q;
  assign bus.WR_VALID = r_wr_valid;
  assign bus.WR_IDX   = r_wr_idx;
  assign bus.WR_PRI   = r_wr_pri;

endmodule

// File: tb/tb_reg_rr_write_arbiter.sv
// tb/tb_reg_rr_write_arbiter.sv - scoreboard bench for the round-robin register write arbiter
module tb_reg_rr_write_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXL = 8;

  typedef struct {
    bit         valid;
    logic [7:0] q;
    int         idx;
    bit         pri;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  exp_t sb_q[$];

  // Reference state, expressed in terms of the behavioural rules.
  int         m_ptr = N - 1;
  bit         m_locked = 0;
  int         m_owner = 0;
  int         m_cnt = 0;
  logic [7:0] m_q = 8'h00;
  bit         m_valid = 0;
  int         m_idx = 0;
  bit         m_pri = 0;

  always #5 CLK = ~CLK;

  reg_rr_write_arbiter_if #(.nreq(N), .idxw(2), .width(W)) bus ();

  reg_rr_write_arbiter #(
    .nreq(N), .idxw(2), .width(W), .init(8'h00), .max_lock(MAXL)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  function automatic int model_grant(bit rst, bit pri, logic [3:0] req, logic [3:0] lock);
    if (!rst || pri) return -1;
`ifdef REG_ARB_LOCK_EN
    if (m_locked && lock[m_owner]) return req[m_owner] ? m_owner : -1;
`else
    if (lock === 4'hx) return -1;
`endif
    for (int k = 1; k <= N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(bit rst, bit pri, logic [7:0] pd, logic [3:0] req,
                              logic [3:0] lock, logic [31:0] din, int g);
    if (!rst) begin
      m_q = 8'h00; m_valid = 0; m_idx = 0; m_pri = 0;
      m_ptr = N - 1; m_locked = 0; m_cnt = 0;
    end else if (pri) begin
      m_q = pd; m_valid = 1; m_pri = 1;
`ifdef REG_ARB_LOCK_EN
      if (m_locked && !lock[m_owner]) begin m_locked = 0; m_cnt = 0; end
`endif
    end else if (g >= 0) begin
      m_q = din[g*8 +: 8]; m_valid = 1; m_pri = 0; m_idx = g; m_ptr = g;
`ifdef REG_ARB_LOCK_EN
      if (m_locked && lock[m_owner]) begin
        m_cnt++;
        if (m_cnt >= MAXL) begin m_locked = 0; m_cnt = 0; end
      end else if (lock[g]) begin
        m_locked = 1; m_owner = g; m_cnt = 1;
      end else begin
        m_locked = 0; m_cnt = 0;
      end
`endif
    end else begin
      m_valid = 0;
`ifdef REG_ARB_LOCK_EN
      m_locked = 0; m_cnt = 0;
`endif
    end
    if (req === 4'hx) m_valid = 0;
  endtask

  task automatic step(input bit rst, input bit pri, input logic [7:0] pd,
                      input logic [3:0] req, input logic [3:0] lock,
                      input logic [31:0] din, output logic [3:0] got);
    int   g;
    logic [3:0] eg;
    exp_t e;
    @(negedge CLK);
    RST_N = rst; bus.PRI_EN = pri; bus.PRI_D = pd;
    bus.REQ = req; bus.LOCK = lock; bus.D_IN = din;
    #1;
    g  = model_grant(rst, pri, req, lock);
    eg = (g < 0) ? 4'h0 : 4'(1 << g);
    got = bus.GNT;
    n_tests++;
    if (bus.GNT !== eg) begin
      n_fail++;
      $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, bus.GNT, eg);
    end
    model_update(rst, pri, pd, req, lock, din, g);
    e.valid = m_valid; e.q = m_q; e.idx = m_idx; e.pri = m_pri;
    sb_q.push_back(e);
    cyc++;
  endtask

  // Monitor: one registered output set per edge, compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (bus.WR_VALID !== e.valid || bus.Q_OUT !== e.q ||
            bus.WR_IDX !== 2'(e.idx) || bus.WR_PRI !== e.pri) begin
          n_fail++;
          $display("FAIL status got v=%b q=%h idx=%0d pri=%b exp v=%b q=%h idx=%0d pri=%b",
                   bus.WR_VALID, bus.Q_OUT, bus.WR_IDX, bus.WR_PRI,
                   e.valid, e.q, e.idx, e.pri);
        end
      end
    end
  end

  task automatic check_seq(input string name, input logic [3:0] got, input int exp_idx);
    n_tests++;
    if (got !== 4'(1 << exp_idx)) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, got, 4'(1 << exp_idx));
    end
  endtask

  initial begin
    logic [3:0]  got;
    logic [31:0] din;
    int          fair_seq[5] = '{0, 1, 2, 3, 0};
    int          wrap_seq[3] = '{0, 3, 0};
`ifdef REG_ARB_LOCK_EN
    int          lock_seq[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 2};
    int          drop_seq[4] = '{1, 1, 1, 2};
`else
    int          lock_seq[4] = '{1, 2, 3, 0};
    int          drop_seq[4] = '{1, 2, 3, 0};
`endif
    din = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.PRI_EN = 0; bus.PRI_D = '0; bus.REQ = '0; bus.LOCK = '0; bus.D_IN = '0;

    // Reset with all requests asserted.
    repeat (2) step(0, 0, 8'h00, 4'hF, 4'h0, din, got);

    // Fairness.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 8'h00, 4'hF, 4'h0, din, got);
      check_seq("fair", got, fair_seq[i]);
    end

    // Priority beats requester 1, then requester 1 wins.
    step(1, 1, 8'hA5, 4'h2, 4'h0, din, got);
    step(1, 0, 8'h00, 4'h2, 4'h0, din, got);
    check_seq("after_pri", got, 1);

    // Wrap / sparse from rr_ptr = 3.
    step(1, 0, 8'h00, 4'h8, 4'h0, din, got);
    check_seq("to_ptr3", got, 3);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h00, 4'h9, 4'h0, din, got);
      check_seq("wrap", got, wrap_seq[i]);
    end

    // Lock: pointer parked at 0 first so requester 1 is next.
    step(0, 0, 8'h00, 4'h0, 4'h0, din, got);
    step(1, 0, 8'h00, 4'h1, 4'h0, din, got);
    foreach (lock_seq[i]) begin
      step(1, 0, 8'h00, 4'hF, 4'h2, din, got);
      check_seq("lock", got, lock_seq[i]);
    end

    // Lock dropped after three grants.
    step(0, 0, 8'h00, 4'h0, 4'h0, din, got);
    step(1, 0, 8'h00, 4'h1, 4'h0, din, got);
    foreach (drop_seq[i]) begin
      step(1, 0, 8'h00, 4'hF, (i < 3) ? 4'h2 : 4'h0, din, got);
      check_seq("lock_drop", got, drop_seq[i]);
    end

    // Randomized traffic, including resets and priority during locks.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0), 8'($urandom),
           4'($urandom), ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
           $urandom, got);
    end

    repeat (2) @(posedge CLK);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d exp=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
